// File: rtl/dma_pkg.sv
// ============================================================
// dma_pkg : register map, CTRL/STAT bit positions and FSM
//           state encoding shared by the DMA controller files
// Revision 1.0
// ============================================================
`default_nettype none

package dma_pkg;

   localparam logic [2:0] DMA_SRCH = 3'd0;
   localparam logic [2:0] DMA_SRCL = 3'd1;
   localparam logic [2:0] DMA_DSTH = 3'd2;
   localparam logic [2:0] DMA_DSTL = 3'd3;
   localparam logic [2:0] DMA_CNTH = 3'd4;
   localparam logic [2:0] DMA_CNTL = 3'd5;
   localparam logic [2:0] DMA_CTRL = 3'd6;
   localparam logic [2:0] DMA_STAT = 3'd7;

   localparam int CTRL_START   = 0;
   localparam int CTRL_IEN     = 1;
   localparam int CTRL_ABORT   = 2;
   localparam int CTRL_BUSY    = 7;
   localparam int STAT_DONE    = 0;
   localparam int STAT_ABORTED = 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_RD   = 3'd2,
      S_RDL  = 3'd3,
      S_WR   = 3'd4,
      S_DONE = 3'd5
   } state_t;

endpackage

`default_nettype wire

// File: rtl/dma_regs.sv
// ============================================================
// dma_regs : CPU register window decode, read mux, CTRL/STAT flags
//            and write-1-to-clear status for dma_ctl
// Revision 1.0
// ============================================================
`default_nettype none

module dma_regs
   import dma_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        rw,
   input  logic [2:0]  Address,
   input  logic [7:0]  DI,
   input  logic        busy,
   input  logic        done_set,
   input  logic        aborted_set,
   input  logic [15:0] src,
   input  logic [15:0] dst,
   input  logic [15:0] cnt,
   output logic [5:0]  ptr_we,
   output logic        start_p,
   output logic        abort_p,
   output logic [7:0]  DO,
   output logic        irq
);

   logic       wr, rd;
   logic       ien_q, ien_d;
   logic       done_q, done_d;
   logic       aborted_q, aborted_d;
   logic [7:0] do_q, do_d;
   logic       irq_q, irq_d;

   always_comb begin
      wr        = cs & ~rw;
      rd        = cs & rw;
      ptr_we    = 6'b0;
      start_p   = 1'b0;
      abort_p   = 1'b0;
      ien_d     = ien_q;
      done_d    = done_q;
      aborted_d = aborted_q;
      do_d      = do_q;

      // Pointer writes are only honoured while the channel is idle
      if (wr && !busy) begin
         case (Address)
            DMA_SRCH: ptr_we[0] = 1'b1;
            DMA_SRCL: ptr_we[1] = 1'b1;
            DMA_DSTH: ptr_we[2] = 1'b1;
            DMA_DSTL: ptr_we[3] = 1'b1;
            DMA_CNTH: ptr_we[4] = 1'b1;
            DMA_CNTL: ptr_we[5] = 1'b1;
            default:  ptr_we    = 6'b0;
         endcase
      end

      if (wr && Address == DMA_CTRL) begin
         ien_d   = DI[CTRL_IEN];
         start_p = DI[CTRL_START] & ~busy;
         abort_p = DI[CTRL_ABORT];
      end

      if (wr && Address == DMA_STAT) begin
         if (DI[STAT_DONE])    done_d    = 1'b0;
         if (DI[STAT_ABORTED]) aborted_d = 1'b0;
      end
      if (done_set)    done_d    = 1'b1;
      if (aborted_set) aborted_d = 1'b1;

      if (rd) begin
         case (Address)
            DMA_SRCH: do_d = src[15:8];
            DMA_SRCL: do_d = src[7:0];
            DMA_DSTH: do_d = dst[15:8];
            DMA_DSTL: do_d = dst[7:0];
            DMA_CNTH: do_d = cnt[15:8];
            DMA_CNTL: do_d = cnt[7:0];
            DMA_CTRL: do_d = {busy, 5'b0, ien_q, 1'b0};
            default:  do_d = {6'b0, aborted_q, done_q};
         endcase
      end

      irq_d = done_d & ien_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ien_q     <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         do_q      <= 8'h00;
         irq_q     <= 1'b0;
      end else begin
         ien_q     <= ien_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         do_q      <= do_d;
         irq_q     <= irq_d;
      end
   end

   assign DO  = do_q;
   assign irq = irq_q;

endmodule

`default_nettype wire

// File: rtl/dma_ctl.sv
// ============================================================
// dma_ctl : single-channel byte DMA controller; takes the bus via
//           hold and copies CNT bytes from SRC to DST
// Revision 1.0
// ============================================================
`default_nettype none

module dma_ctl
   import dma_pkg::*;
#(
   parameter int SETTLE = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic [2:0]  Address,
   input  logic [7:0]  DI,
   output logic [7:0]  DO,
   input  logic        rw,
   output logic        hold,
   output logic        bus_own,
   output logic [15:0] m_addr,
   output logic [7:0]  m_dout,
   output logic        m_rw,
   output logic        m_vma,
   input  logic [7:0]  m_din,
   output logic        irq
);

   localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_t               state_q, state_d;
   logic [15:0]          src_q, src_d;
   logic [15:0]          dst_q, dst_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [SETTLE_W-1:0]  settle_q, settle_d;
   logic [7:0]           buf_q, buf_d;
   logic                 abort_pend_q, abort_pend_d;
   logic                 hold_q, hold_d;
   logic                 bus_own_q, bus_own_d;
   logic [15:0]          m_addr_q, m_addr_d;
   logic [7:0]           m_dout_q, m_dout_d;
   logic                 m_rw_q, m_rw_d;
   logic                 m_vma_q, m_vma_d;

   logic        busy;
   logic [5:0]  ptr_we;
   logic        start_p, abort_p;
   logic        done_set, aborted_set;
   logic [15:0] cnt_dec;

   assign busy    = (state_q != S_IDLE);
   assign cnt_dec = cnt_q - 16'd1;

   dma_regs u_regs (
      .clk         (clk),
      .rst         (rst),
      .cs          (cs),
      .rw          (rw),
      .Address     (Address),
      .DI          (DI),
      .busy        (busy),
      .done_set    (done_set),
      .aborted_set (aborted_set),
      .src         (src_q),
      .dst         (dst_q),
      .cnt         (cnt_q),
      .ptr_we      (ptr_we),
      .start_p     (start_p),
      .abort_p     (abort_p),
      .DO          (DO),
      .irq         (irq)
   );

   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      dst_d        = dst_q;
      cnt_d        = cnt_q;
      settle_d     = settle_q;
      buf_d        = buf_q;
      abort_pend_d = abort_pend_q;
      done_set     = 1'b0;
      aborted_set  = 1'b0;

      if (ptr_we[0]) src_d[15:8] = DI;
      if (ptr_we[1]) src_d[7:0]  = DI;
      if (ptr_we[2]) dst_d[15:8] = DI;
      if (ptr_we[3]) dst_d[7:0]  = DI;
      if (ptr_we[4]) cnt_d[15:8] = DI;
      if (ptr_we[5]) cnt_d[7:0]  = DI;

      case (state_q)
         S_IDLE: begin
            abort_pend_d = 1'b0;
            if (start_p) begin
               if (cnt_q == 16'd0) begin
                  done_set = 1'b1;
               end else begin
                  state_d  = S_REQ;
                  settle_d = SETTLE_W'(SETTLE - 1);
               end
            end
         end
         S_REQ: begin
            if (abort_p) begin
               abort_pend_d = 1'b1;
               state_d      = S_DONE;
            end else if (settle_q == '0) begin
               state_d = S_RD;
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end
         S_RD: begin
            if (abort_p) abort_pend_d = 1'b1;
            state_d = S_RDL;
         end
         S_RDL: begin
            if (abort_p) abort_pend_d = 1'b1;
            buf_d   = m_din;
            state_d = S_WR;
         end
         S_WR: begin
            if (abort_p) abort_pend_d = 1'b1;
            src_d = src_q + 16'd1;
            dst_d = dst_q + 16'd1;
            cnt_d = cnt_dec;
            // Abort is only honoured once the current byte is fully written
            if (cnt_dec == 16'd0 || abort_pend_q || abort_p)
               state_d = S_DONE;
            else
               state_d = S_RD;
         end
         S_DONE: begin
            done_set    = 1'b1;
            aborted_set = abort_pend_q;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Bus outputs are registered from the next state
      hold_d    = (state_d != S_IDLE);
      m_vma_d   = (state_d == S_RD) || (state_d == S_RDL) || (state_d == S_WR);
      bus_own_d = m_vma_d || (state_d == S_DONE && state_q == S_WR);
      m_rw_d    = (state_d != S_WR);
      m_addr_d  = m_addr_q;
      m_dout_d  = m_dout_q;
      if (state_d == S_RD || state_d == S_RDL) m_addr_d = src_d;
      if (state_d == S_WR) begin
         m_addr_d = dst_d;
         m_dout_d = buf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         src_q        <= 16'h0000;
         dst_q        <= 16'h0000;
         cnt_q        <= 16'h0000;
         settle_q     <= '0;
         buf_q        <= 8'h00;
         abort_pend_q <= 1'b0;
         hold_q       <= 1'b0;
         bus_own_q    <= 1'b0;
         m_addr_q     <= 16'h0000;
         m_dout_q     <= 8'h00;
         m_rw_q       <= 1'b1;
         m_vma_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         cnt_q        <= cnt_d;
         settle_q     <= settle_d;
         buf_q        <= buf_d;
         abort_pend_q <= abort_pend_d;
         hold_q       <= hold_d;
         bus_own_q    <= bus_own_d;
         m_addr_q     <= m_addr_d;
         m_dout_q     <= m_dout_d;
         m_rw_q       <= m_rw_d;
         m_vma_q      <= m_vma_d;
      end
   end

   assign hold    = hold_q;
   assign bus_own = bus_own_q;
   assign m_addr  = m_addr_q;
   assign m_dout  = m_dout_q;
   assign m_rw    = m_rw_q;
   assign m_vma   = m_vma_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_ctl.sv
// ============================================================
// tb_dma_ctl : self-checking bench for dma_ctl with a 64 KB
//              memory model and a write scoreboard
// Revision 1.0
// ============================================================
`default_nettype none

module tb_dma_ctl;
   import dma_pkg::*;

   localparam int SETTLE = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cs = 1'b0;
   logic        rw = 1'b1;
   logic [2:0]  addr = 3'd0;
   logic [7:0]  di = 8'h00;
   logic [7:0]  dout;
   logic        hold, bus_own, m_rw, m_vma, irq;
   logic [15:0] m_addr;
   logic [7:0]  m_dout;
   logic [7:0]  m_din = 8'h00;

   always #5 clk = ~clk;

   dma_ctl #(.SETTLE(SETTLE)) dut (
      .clk     (clk),
      .rst     (rst),
      .cs      (cs),
      .Address (addr),
      .DI      (di),
      .DO      (dout),
      .rw      (rw),
      .hold    (hold),
      .bus_own (bus_own),
      .m_addr  (m_addr),
      .m_dout  (m_dout),
      .m_rw    (m_rw),
      .m_vma   (m_vma),
      .m_din   (m_din),
      .irq     (irq)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int n_vma  = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] + (a[15:8] * 8'd3) + 8'h11;
   endfunction

   // memory: one-cycle read latency, write on the WR edge
   logic [7:0] mem [0:65535];
   initial for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
   always @(posedge clk) begin
      if (bus_own && m_vma) begin
         if (m_rw) m_din <= mem[m_addr];
         else      mem[m_addr] = m_dout;
      end
   end

   typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
   wr_t exp_q[$];

   always @(negedge clk) begin
      if (!bus_own) chk("vma_wo_own", {31'b0, m_vma}, 32'd0);
      if (m_vma) n_vma++;
      if (bus_own && m_vma && !m_rw) begin
         if (exp_q.size() == 0) begin
            chk("wr_queue", 32'(exp_q.size()), 32'd1);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", {16'b0, m_addr}, {16'b0, e.a});
            chk("wr_data", {24'b0, m_dout}, {24'b0, e.d});
         end
      end
   end

   task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
      cs = 1'b1; rw = 1'b0; addr = a; di = d;
      @(negedge clk);
      cs = 1'b0; rw = 1'b1;
   endtask

   task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
      cs = 1'b1; rw = 1'b1; addr = a;
      @(negedge clk);
      cs = 1'b0;
      d = dout;
   endtask

   task automatic rd16(input logic [2:0] hi, output logic [15:0] v);
      logic [7:0] h, l;
      cpu_rd(hi, h);
      cpu_rd(3'(hi + 3'd1), l);
      v = {h, l};
   endtask

   task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
      cpu_wr(DMA_SRCH, s[15:8]); cpu_wr(DMA_SRCL, s[7:0]);
      cpu_wr(DMA_DSTH, d[15:8]); cpu_wr(DMA_DSTL, d[7:0]);
      cpu_wr(DMA_CNTH, n[15:8]); cpu_wr(DMA_CNTL, n[7:0]);
   endtask

   task automatic push_exp(input logic [15:0] s, input logic [15:0] d, input int n);
      logic [15:0] ss, dd;
      ss = s; dd = d;
      for (int k = 0; k < n; k++) begin
         exp_q.push_back('{a: dd, d: pat(ss)});
         ss = ss + 16'd1;
         dd = dd + 16'd1;
      end
   endtask

   task automatic hold_len(output int n);
      n = 0;
      while (hold && n < 500) begin
         n++;
         @(negedge clk);
      end
      if (n >= 500) chk("hold_timeout", 32'(n), 32'd0);
   endtask

   logic [7:0]  r8;
   logic [15:0] r16;
   int          hl, v0;

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_hold",  {31'b0, hold},    32'd0);
      chk("rst_own",   {31'b0, bus_own}, 32'd0);
      chk("rst_vma",   {31'b0, m_vma},   32'd0);
      chk("rst_rw",    {31'b0, m_rw},    32'd1);
      chk("rst_addr",  {16'b0, m_addr},  32'd0);
      chk("rst_dout",  {24'b0, m_dout},  32'd0);
      chk("rst_irq",   {31'b0, irq},     32'd0);
      chk("rst_DO",    {24'b0, dout},    32'd0);

      // 4-byte ROM to RAM copy
      setup(16'hF000, 16'h0010, 16'h0004);
      push_exp(16'hF000, 16'h0010, 4);
      cpu_wr(DMA_CTRL, 8'h01);
      hold_len(hl);
      chk("t1_hold_len", 32'(hl), 32'(SETTLE + 12 + 1));
      chk("t1_queue", 32'(exp_q.size()), 32'd0);
      for (int k = 0; k < 4; k++)
         chk("t1_mem", {24'b0, mem[16'h0010 + 16'(k)]}, {24'b0, pat(16'hF000 + 16'(k))});
      cpu_rd(DMA_STAT, r8); chk("t1_stat", {24'b0, r8}, 32'h01);
      cpu_rd(DMA_CTRL, r8); chk("t1_ctrl", {24'b0, r8}, 32'h00);
      chk("t1_irq", {31'b0, irq}, 32'd0);
      rd16(DMA_SRCH, r16); chk("t1_src", {16'b0, r16}, 32'hF004);
      rd16(DMA_CNTH, r16); chk("t1_cnt", {16'b0, r16}, 32'h0000);
      cpu_wr(DMA_STAT, 8'h01);

      // zero count: done without a bus request
      cpu_wr(DMA_CTRL, 8'h01);
      chk("t2_hold", {31'b0, hold}, 32'd0);
      cpu_rd(DMA_STAT, r8); chk("t2_stat", {24'b0, r8}, 32'h01);
      hl = 0;
      for (int k = 0; k < 5; k++) begin
         if (hold) hl++;
         @(negedge clk);
      end
      chk("t2_hold_never", 32'(hl), 32'd0);
      cpu_wr(DMA_STAT, 8'h01);

      // address wrap on both pointers
      setup(16'hFFFE, 16'h00FE, 16'h0003);
      push_exp(16'hFFFE, 16'h00FE, 3);
      cpu_wr(DMA_CTRL, 8'h01);
      hold_len(hl);
      chk("t3_hold_len", 32'(hl), 32'(SETTLE + 9 + 1));
      chk("t3_queue", 32'(exp_q.size()), 32'd0);
      rd16(DMA_SRCH, r16); chk("t3_src", {16'b0, r16}, 32'h0001);
      rd16(DMA_DSTH, r16); chk("t3_dst", {16'b0, r16}, 32'h0101);
      cpu_wr(DMA_STAT, 8'h01);

      // abort in REQ with interrupts enabled
      setup(16'h4000, 16'h0600, 16'h0010);
      v0 = n_vma;
      cpu_wr(DMA_CTRL, 8'h03);
      chk("t4_hold_req", {31'b0, hold}, 32'd1);
      cpu_wr(DMA_CTRL, 8'h06);
      hold_len(hl);
      chk("t4_hold_len", 32'(hl), 32'd1);
      chk("t4_irq", {31'b0, irq}, 32'd1);
      chk("t4_no_bus", 32'(n_vma - v0), 32'd0);
      cpu_rd(DMA_STAT, r8); chk("t4_stat", {24'b0, r8}, 32'h03);
      rd16(DMA_SRCH, r16); chk("t4_src", {16'b0, r16}, 32'h4000);
      cpu_wr(DMA_STAT, 8'h03);
      chk("t4_irq_clr", {31'b0, irq}, 32'd0);

      // reset during the second byte's write cycle
      setup(16'h3000, 16'h0400, 16'h0005);
      push_exp(16'h3000, 16'h0400, 5);
      cpu_wr(DMA_CTRL, 8'h01);
      repeat (SETTLE + 5) @(negedge clk);
      chk("t5_in_wr", {30'b0, m_vma, m_rw}, 32'b10);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_hold", {31'b0, hold},    32'd0);
      chk("t5_own",  {31'b0, bus_own}, 32'd0);
      chk("t5_vma",  {31'b0, m_vma},   32'd0);
      chk("t5_left", 32'(exp_q.size()), 32'd3);
      exp_q.delete();
      for (int k = 0; k < 8; k++) begin
         cpu_rd(3'(k), r8);
         chk("t5_reg", {24'b0, r8}, 32'h00);
      end

      // pointer write and second start while busy are ignored
      setup(16'h2000, 16'h0500, 16'h0004);
      push_exp(16'h2000, 16'h0500, 4);
      cpu_wr(DMA_CTRL, 8'h01);
      cpu_wr(DMA_SRCH, 8'h70);
      cpu_wr(DMA_CTRL, 8'h01);
      hold_len(hl);
      chk("t6_hold_len", 32'(hl), 32'(SETTLE + 12 + 1 - 2));
      chk("t6_queue", 32'(exp_q.size()), 32'd0);
      rd16(DMA_SRCH, r16); chk("t6_src", {16'b0, r16}, 32'h2004);
      rd16(DMA_DSTH, r16); chk("t6_dst", {16'b0, r16}, 32'h0504);
      rd16(DMA_CNTH, r16); chk("t6_cnt", {16'b0, r16}, 32'h0000);
      repeat (4) @(negedge clk);
      chk("end_queue", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
